// File: rtl/adder_operand_capture_if.sv
// Operand-capture bus between the LCD/touchscreen controller side and the adder.
// The master drives entered values; the slave returns the registered adder inputs.
interface adder_operand_capture_if;
  logic        input_valid;
  logic [31:0] input_value;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        cin;
  logic        sel_db;
  logic        op_update;
  logic [7:0]  capture_count;

  modport master (
    output input_valid,
    output input_value,
    input  operand1,
    input  operand2,
    input  cin,
    input  sel_db,
    input  op_update,
    input  capture_count
  );

  modport slave (
    input  input_valid,
    input  input_value,
    output operand1,
    output operand2,
    output cin,
    output sel_db,
    output op_update,
    output capture_count
  );
endinterface

// File: rtl/adder_operand_capture.sv
// Switch synchronise/debounce and touchscreen operand capture feeding the 32-bit adder.
// All outputs are registered; op_update flags any change of operand1, operand2 or cin.
module adder_operand_capture #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     input_sel,
  input  logic                     sw_cin,
  adder_operand_capture_if.slave   bus
);

  localparam int               DATA_W   = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic             lvl;
    logic [CNT_W-1:0] cnt;
  } db_state_t;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample discards the progress made so far.
  function automatic db_state_t db_step(input logic s, input db_state_t cur);
    db_state_t nxt;
    nxt = cur;
    if (s == cur.lvl) begin
      nxt.cnt = '0;
    end else if (cur.cnt == CNT_LAST) begin
      nxt.lvl = s;
      nxt.cnt = '0;
    end else begin
      nxt.cnt = cur.cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic differs(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
    return (a != b);
  endfunction

  logic      sel_sync_p0, sel_sync_p1;
  logic      cin_sync_p0, cin_sync_p1;
  db_state_t sel_st_p2, sel_st_nxt;
  db_state_t cin_st_p2, cin_st_nxt;

  logic              valid_d;
  logic              armed;
  logic              cap_evt;
  logic              op1_chg, op2_chg, cin_chg;
  logic [DATA_W-1:0] operand1_r, operand2_r;
  logic              op_update_r;
  logic [7:0]        capture_count_r;

  // Stage p0/p1: two-flop synchronisers for the raw board switches
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_sync_p0 <= 1'b0;
      sel_sync_p1 <= 1'b0;
      cin_sync_p0 <= 1'b0;
      cin_sync_p1 <= 1'b0;
    end else begin
      sel_sync_p0 <= input_sel;
      sel_sync_p1 <= sel_sync_p0;
      cin_sync_p0 <= sw_cin;
      cin_sync_p1 <= cin_sync_p0;
    end
  end

  always_comb begin
    sel_st_nxt = db_step(sel_sync_p1, sel_st_p2);
    cin_st_nxt = db_step(cin_sync_p1, cin_st_p2);
  end

  // Stage p2: debounced levels and their stability counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_st_p2 <= '0;
      cin_st_p2 <= '0;
    end else begin
      sel_st_p2 <= sel_st_nxt;
      cin_st_p2 <= cin_st_nxt;
    end
  end

  // armed blocks a capture until input_valid has been seen low after reset,
  // so a value still being presented across reset release is not re-taken.
  always_comb begin
    cap_evt = bus.input_valid & ~valid_d & armed;
    op1_chg = cap_evt & ~sel_st_p2.lvl & differs(bus.input_value, operand1_r);
    op2_chg = cap_evt &  sel_st_p2.lvl & differs(bus.input_value, operand2_r);
    cin_chg = (cin_st_nxt.lvl != cin_st_p2.lvl);
  end

  // Capture stage: edge detect, operand registers, change strobe and counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_d         <= 1'b0;
      armed           <= 1'b0;
      operand1_r      <= '0;
      operand2_r      <= '0;
      op_update_r     <= 1'b0;
      capture_count_r <= '0;
    end else begin
      valid_d     <= bus.input_valid;
      if (!bus.input_valid) begin
        armed <= 1'b1;
      end
      op_update_r <= op1_chg | op2_chg | cin_chg;
      if (cap_evt) begin
        capture_count_r <= capture_count_r + 8'd1;
        if (sel_st_p2.lvl) begin
          operand2_r <= bus.input_value;
        end else begin
          operand1_r <= bus.input_value;
        end
      end
    end
  end

  assign bus.operand1      = operand1_r;
  assign bus.operand2      = operand2_r;
  assign bus.cin           = cin_st_p2.lvl;
  assign bus.sel_db        = sel_st_p2.lvl;
  assign bus.op_update     = op_update_r;
  assign bus.capture_count = capture_count_r;

endmodule

// File: tb/tb_adder_operand_capture.sv
// Directed bench for adder_operand_capture with a short debounce window (4 cycles).
module tb_adder_operand_capture;

  logic clk = 1'b0;
  logic resetn;
  logic input_sel;
  logic sw_cin;
  int   checks = 0;
  int   errors = 0;
  logic seen;

  adder_operand_capture_if bus ();

  adder_operand_capture #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .input_sel(input_sel),
    .sw_cin   (sw_cin),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn          = 1'b0;
    input_sel       = 1'b0;
    sw_cin          = 1'b0;
    bus.input_valid = 1'b1;
    bus.input_value = 32'hFFFF_FFFF;

    // reset with valid held high
    tick(3);
    chk("rst_op1",   bus.operand1, 32'h0);
    chk("rst_op2",   bus.operand2, 32'h0);
    chk("rst_cin",   32'(bus.cin), 32'h0);
    chk("rst_sel",   32'(bus.sel_db), 32'h0);
    chk("rst_upd",   32'(bus.op_update), 32'h0);
    chk("rst_cnt",   32'(bus.capture_count), 32'h0);
    resetn = 1'b1;
    tick(3);
    chk("held_after_rst_cnt", 32'(bus.capture_count), 32'h0);
    chk("held_after_rst_op1", bus.operand1, 32'h0);
    bus.input_valid = 1'b0;
    tick();

    // basic capture into operand1
    bus.input_value = 32'h1234_5678;
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
    chk("basic_op1", bus.operand1, 32'h1234_5678);
    chk("basic_upd", 32'(bus.op_update), 32'h1);
    chk("basic_cnt", 32'(bus.capture_count), 32'h1);
    chk("basic_op2", bus.operand2, 32'h0);
    tick();
    chk("basic_upd_end", 32'(bus.op_update), 32'h0);

    // select debounce then held valid routes once to operand2
    input_sel = 1'b1;
    tick(5);
    chk("sel_not_yet", 32'(bus.sel_db), 32'h0);
    tick();
    chk("sel_db_set", 32'(bus.sel_db), 32'h1);
    chk("sel_no_upd", 32'(bus.op_update), 32'h0);
    bus.input_value = 32'hDEAD_BEEF;
    bus.input_valid = 1'b1;
    tick();
    chk("held_op2", bus.operand2, 32'hDEAD_BEEF);
    chk("held_upd", 32'(bus.op_update), 32'h1);
    chk("held_cnt", 32'(bus.capture_count), 32'h2);
    chk("held_op1", bus.operand1, 32'h1234_5678);
    tick(9);
    chk("held_cnt_once", 32'(bus.capture_count), 32'h2);
    chk("held_upd_low", 32'(bus.op_update), 32'h0);
    bus.input_valid = 1'b0;
    tick();
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
    chk("same_cnt", 32'(bus.capture_count), 32'h3);
    chk("same_upd", 32'(bus.op_update), 32'h0);
    tick();

    // carry-in bounce is rejected
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sw_cin = (i < 8) ? ((i % 4) < 2) : 1'b0;
      tick();
      seen = seen | bus.op_update | bus.cin;
    end
    chk("bounce_rejected", 32'(seen), 32'h0);
    sw_cin = 1'b1;
    tick(5);
    chk("cin_not_yet", 32'(bus.cin), 32'h0);
    tick();
    chk("cin_set", 32'(bus.cin), 32'h1);
    chk("cin_upd", 32'(bus.op_update), 32'h1);
    tick();
    chk("cin_upd_end", 32'(bus.op_update), 32'h0);

    // select race: capture before the new select is accepted
    input_sel = 1'b0;
    tick(6);
    chk("sel_back", 32'(bus.sel_db), 32'h0);
    input_sel = 1'b1;
    tick(2);
    bus.input_value = 32'h0000_00AA;
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
    chk("race_op1", bus.operand1, 32'h0000_00AA);
    chk("race_op2", bus.operand2, 32'hDEAD_BEEF);
    chk("race_upd", 32'(bus.op_update), 32'h1);
    chk("race_cnt", 32'(bus.capture_count), 32'h4);
    tick(3);
    chk("race_sel_late", 32'(bus.sel_db), 32'h1);

    // capture counter wrap
    for (int i = 0; i < 252; i++) begin
      bus.input_value = 32'h100 + 32'(i);
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      tick();
    end
    chk("wrap_zero", 32'(bus.capture_count), 32'h0);
    chk("wrap_op2", bus.operand2, 32'h0000_01FB);
    for (int i = 0; i < 4; i++) begin
      bus.input_value = 32'h200 + 32'(i);
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      tick();
    end
    chk("wrap_again", 32'(bus.capture_count), 32'h4);

    // reset in the middle of a cin debounce
    sw_cin = 1'b0;
    tick(4);
    chk("mid_cin_held", 32'(bus.cin), 32'h1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_cin", 32'(bus.cin), 32'h0);
    chk("mid_rst_cnt", 32'(bus.capture_count), 32'h0);
    chk("mid_rst_op2", bus.operand2, 32'h0);
    sw_cin = 1'b1;
    tick();
    resetn = 1'b1;
    tick(5);
    chk("post_rst_cin_wait", 32'(bus.cin), 32'h0);
    tick();
    chk("post_rst_cin_set", 32'(bus.cin), 32'h1);
    chk("post_rst_upd", 32'(bus.op_update), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
